// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the multiply/divide issue wrapper: operator encodings,
// signed-mode bit positions and the wrapper state machine encoding.
package ibex_multdiv_issue_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  // Bit positions inside the 2-bit signed-mode field.
  localparam int unsigned MD_SIGN_A_BIT = 0;
  localparam int unsigned MD_SIGN_B_BIT = 1;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_DRAIN = 2'd2,
    MD_RESP  = 2'd3
  } md_issue_state_e;

  // Width of the issue-to-valid watchdog counter.
  localparam int unsigned MD_WD_W = 6;

  // Multiply operators select the multiplier half of the unit.
  function automatic logic md_is_mult(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_adder.sv
// Shared 34-bit adder and divisor zero detect. The unit steers both adder
// operands; bit 0 of each extended operand is its own carry injection, so
// the useful 32-bit sum sits in bits [32:1].
module ibex_multdiv_adder (
  input  logic [32:0] operand_a_i,
  input  logic [32:0] operand_b_i,
  input  logic [31:0] op_b_i,
  output logic [33:0] adder_ext_o,
  output logic [31:0] adder_o,
  output logic        equal_to_zero_o
);

  assign adder_ext_o     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
  assign adder_o         = adder_ext_o[32:1];
  assign equal_to_zero_o = (op_b_i == 32'd0);

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue/writeback wrapper around the iterative multiply/divide unit.
// Holds one operation's operands stable for the unit, keeps the enables up
// until the unit's result pulse (the unit cannot be aborted), and presents
// the captured result to writeback with a valid/ready handshake.
module ibex_multdiv_issue
  import ibex_multdiv_issue_pkg::*;
#(
  parameter int unsigned MAX_LAT = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output logic [1:0]  md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic [32:0] md_alu_operand_a_i,
  input  logic [32:0] md_alu_operand_b_i,
  output logic [33:0] md_alu_adder_ext_o,
  output logic [31:0] md_alu_adder_o,
  output logic        md_equal_to_zero_o,
  input  logic [31:0] md_result_i,
  input  logic        md_valid_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_rd_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [MD_WD_W-1:0] WD_LIMIT = MD_WD_W'(MAX_LAT);

  md_issue_state_e    state_q, state_d;
  md_op_e             op_q, op_d;
  logic [1:0]         sm_q, sm_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [4:0]         rsp_rd_q, rsp_rd_d;
  logic [MD_WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic               err_q, err_d;

  logic accept;
  logic capture;
  logic unit_active;

  assign accept      = req_valid_i & req_ready_o;
  assign unit_active = (state_q == MD_RUN) || (state_q == MD_DRAIN);
  // A flush in the same cycle as the result pulse drops that result.
  assign capture     = (state_q == MD_RUN) & md_valid_i & ~flush_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DRAIN waits out an operation the unit cannot abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) state_d = MD_RUN;
      end
      MD_RUN: begin
        if (md_valid_i)   state_d = flush_i ? MD_IDLE : MD_RESP;
        else if (flush_i) state_d = MD_DRAIN;
      end
      MD_DRAIN: begin
        if (md_valid_i) state_d = MD_IDLE;
      end
      MD_RESP: begin
        if (flush_i)          state_d = MD_IDLE;
        else if (accept)      state_d = MD_RUN;
        else if (rsp_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Outputs per state; enables are only ever high while the unit computes.
  always_comb begin
    req_ready_o  = 1'b0;
    md_mult_en_o = 1'b0;
    md_div_en_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    unique case (state_q)
      MD_IDLE: req_ready_o = 1'b1;
      MD_RUN, MD_DRAIN: begin
        md_mult_en_o = md_is_mult(op_q);
        md_div_en_o  = ~md_is_mult(op_q);
      end
      MD_RESP: begin
        rsp_valid_o = 1'b1;
        // A flush discards the response, so it must not also start a new op.
        req_ready_o = rsp_ready_i & ~flush_i;
      end
      default: ;
    endcase
  end

  // Operand/result capture and the issue-to-valid watchdog.
  always_comb begin
    op_d         = op_q;
    sm_d         = sm_q;
    a_d          = a_q;
    b_d          = b_q;
    rd_d         = rd_q;
    rsp_result_d = rsp_result_q;
    rsp_rd_d     = rsp_rd_q;
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;

    if (accept) begin
      op_d = md_op_e'(req_operator_i);
      sm_d = req_signed_mode_i;
      a_d  = req_op_a_i;
      b_d  = req_op_b_i;
      rd_d = req_rd_i;
    end

    if (capture) begin
      rsp_result_d = md_result_i;
      rsp_rd_d     = rd_q;
    end else if ((state_q == MD_RESP) && flush_i) begin
      rsp_result_d = 32'd0;
      rsp_rd_d     = 5'd0;
    end

    if (accept) begin
      wd_cnt_d = '0;
    end else if (unit_active && (wd_cnt_q != WD_LIMIT)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end

    if (unit_active && !md_valid_i && (wd_cnt_d == WD_LIMIT)) begin
      err_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q         <= MD_OP_MULL;
      sm_q         <= 2'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rd_q         <= 5'd0;
      rsp_result_q <= 32'd0;
      rsp_rd_q     <= 5'd0;
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      op_q         <= op_d;
      sm_q         <= sm_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rd_q         <= rd_d;
      rsp_result_q <= rsp_result_d;
      rsp_rd_q     <= rsp_rd_d;
      wd_cnt_q     <= wd_cnt_d;
      err_q        <= err_d;
    end
  end

  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign rsp_result_o     = rsp_result_q;
  assign rsp_rd_o         = rsp_rd_q;
  assign busy_o           = (state_q != MD_IDLE);
  assign err_o            = err_q;

  ibex_multdiv_adder u_adder (
    .operand_a_i     (md_alu_operand_a_i),
    .operand_b_i     (md_alu_operand_b_i),
    .op_b_i          (b_q),
    .adder_ext_o     (md_alu_adder_ext_o),
    .adder_o         (md_alu_adder_o),
    .equal_to_zero_o (md_equal_to_zero_o)
  );

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for the multiply/divide issue wrapper. A behavioural model of the
// iterative unit answers through md_valid_i/md_result_i with the unit's
// latencies; expected responses are queued at issue and popped on output.
module tb_ibex_multdiv_issue;
  import ibex_multdiv_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_operator_i = 2'd0;
  logic [1:0]  req_signed_mode_i = 2'd0;
  logic [31:0] req_op_a_i = 32'd0;
  logic [31:0] req_op_b_i = 32'd0;
  logic [4:0]  req_rd_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        md_mult_en_o, md_div_en_o;
  logic [1:0]  md_operator_o, md_signed_mode_o;
  logic [31:0] md_op_a_o, md_op_b_o;
  logic [32:0] md_alu_operand_a_i = 33'd0;
  logic [32:0] md_alu_operand_b_i = 33'd0;
  logic [33:0] md_alu_adder_ext_o;
  logic [31:0] md_alu_adder_o;
  logic        md_equal_to_zero_o;
  logic [31:0] md_result_i;
  logic        md_valid_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_rd_o;
  logic        busy_o, err_o;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ibex_multdiv_issue #(.MAX_LAT(40)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_alu_operand_a_i(md_alu_operand_a_i), .md_alu_operand_b_i(md_alu_operand_b_i),
    .md_alu_adder_ext_o(md_alu_adder_ext_o), .md_alu_adder_o(md_alu_adder_o),
    .md_equal_to_zero_o(md_equal_to_zero_o),
    .md_result_i(md_result_i), .md_valid_i(md_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_rd_o(rsp_rd_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  // ---------------- behavioural model of the iterative unit ----------------
  bit          unit_stall = 1'b0;
  int unsigned u_cnt;
  logic        u_valid;
  logic [31:0] u_result;

  function automatic logic [31:0] unit_calc(logic [1:0] op, logic [1:0] sm,
                                            logic [31:0] a, logic [31:0] b);
    logic signed [32:0] ae, be, q;
    logic signed [65:0] p;
    ae = {sm[MD_SIGN_A_BIT] & a[31], a};
    be = {sm[MD_SIGN_B_BIT] & b[31], b};
    p  = ae * be;
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = ae / be;
        return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = ae % be;
        return q[31:0];
      end
    endcase
  endfunction

  function automatic int unsigned unit_lat(logic [1:0] op, logic [31:0] b);
    if (!op[1]) return 34;
    return (b == 32'd0) ? 3 : 38;
  endfunction

  // Counts enabled cycles (freezing when enables drop) and pulses valid once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt    <= 0;
      u_valid  <= 1'b0;
      u_result <= 32'd0;
    end else if (u_valid) begin
      u_cnt    <= 0;
      u_valid  <= 1'b0;
      u_result <= 32'hDEAD_BEEF;
    end else if (md_mult_en_o | md_div_en_o) begin
      u_cnt <= u_cnt + 1;
      if (!unit_stall && (u_cnt + 1 == unit_lat(md_operator_o, md_op_b_o) - 1)) begin
        u_valid  <= 1'b1;
        u_result <= unit_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
      end
    end
  end

  assign md_valid_i  = u_valid;
  assign md_result_i = u_result;

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  // Called #1 after a clock edge; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input bit push, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    if (push) sb.push_back('{res: exp, rd: rd});
    req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = req_ready_o;
      @(posedge clk); #1;
      n++;
    end
    req_valid_i = 1'b0;
    $display("issue op=%0d sm=%0d a=%h b=%h rd=%0d accepted=%0d", op, sm, a, b, rd, ok);
  endtask

  // Edges from the accept edge until rsp_valid_o; also ANDs the zero detect.
  task automatic wait_rsp(output int lat, output bit ez_all);
    lat    = 0;
    ez_all = md_equal_to_zero_o;
    while (!rsp_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      ez_all = ez_all & md_equal_to_zero_o;
    end
  endtask

  // Pops the expected entry, samples the response and completes the handshake.
  task automatic take_rsp(output exp_t e, output logic [31:0] r, output logic [4:0] d);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{res: 32'hBAD0_BAD0, rd: 5'd31};
    r = rsp_result_o;
    d = rsp_rd_o;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    $display("rsp result=%h rd=%0d expected=%h rd=%0d", r, d, e.res, e.rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_o); else n_pass++;
    n_checks++; if ({md_mult_en_o, md_div_en_o} !== 2'b00) $display("FAIL reset_en got=%b%b exp=00", md_mult_en_o, md_div_en_o); else n_pass++;
    n_checks++; if ({md_op_a_o, md_op_b_o} !== 64'd0) $display("FAIL reset_ops got=%h_%h exp=0", md_op_a_o, md_op_b_o); else n_pass++;
    n_checks++; if ({md_operator_o, md_signed_mode_o} !== 4'd0) $display("FAIL reset_opsm got=%h exp=0", {md_operator_o, md_signed_mode_o}); else n_pass++;
    n_checks++; if ({rsp_result_o, rsp_rd_o} !== 37'd0) $display("FAIL reset_rsp got=%h/%0d exp=0", rsp_result_o, rsp_rd_o); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL idle_ready got=%b exp=1", req_ready_o); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_adder();
    logic [32:0] ta[3];
    logic [32:0] tb[3];
    logic [33:0] te[3];
    logic [31:0] ts[3];
    ta = '{33'h0_0000_0003, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF};
    tb = '{33'h0_0000_0005, 33'h0_0000_0001, 33'h1_FFFF_FFFF};
    te = '{34'h0_0000_0008, 34'h2_0000_0000, 34'h3_FFFF_FFFE};
    ts = '{32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      md_alu_operand_a_i = ta[i];
      md_alu_operand_b_i = tb[i];
      #1;
      $display("adder a=%h b=%h ext=%h sum=%h", ta[i], tb[i], md_alu_adder_ext_o, md_alu_adder_o);
      n_checks++; if (md_alu_adder_ext_o !== te[i]) $display("FAIL adder_ext[%0d] got=%h exp=%h", i, md_alu_adder_ext_o, te[i]); else n_pass++;
      n_checks++; if (md_alu_adder_o !== ts[i]) $display("FAIL adder_sum[%0d] got=%h exp=%h", i, md_alu_adder_o, ts[i]); else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [1:0]  t_op[4];
    logic [1:0]  t_sm[4];
    logic [31:0] t_a[4];
    logic [31:0] t_b[4];
    logic [31:0] t_e[4];
    bit ok, ez;
    int lat;
    exp_t e;
    logic [31:0] r;
    logic [4:0] d;
    t_op = '{2'd0, 2'd1, 2'd1, 2'd1};
    t_sm = '{2'b11, 2'b11, 2'b00, 2'b00};
    t_a  = '{32'h0000_0007, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    t_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    t_e  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_sm[i], t_a[i], t_b[i], 5'(i + 5), t_e[i], 1'b1, ok);
      n_checks++; if (!ok) $display("FAIL mul_accept[%0d] got=0 exp=1", i); else n_pass++;
      wait_rsp(lat, ez);
      n_checks++; if (lat != 34) $display("FAIL mul_latency[%0d] got=%0d exp=34", i, lat); else n_pass++;
      take_rsp(e, r, d);
      n_checks++; if (r !== e.res) $display("FAIL mul_result[%0d] got=%h exp=%h", i, r, e.res); else n_pass++;
      n_checks++; if (d !== e.rd) $display("FAIL mul_rd[%0d] got=%0d exp=%0d", i, d, e.rd); else n_pass++;
    end
  endtask

  task automatic test_div();
    logic [1:0]  t_op[4];
    logic [1:0]  t_sm[4];
    logic [31:0] t_a[4];
    logic [31:0] t_b[4];
    logic [31:0] t_e[4];
    int          t_l[4];
    bit ok, ez;
    int lat;
    exp_t e;
    logic [31:0] r;
    logic [4:0] d;
    t_op = '{2'd2, 2'd3, 2'd2, 2'd3};
    t_sm = '{2'b11, 2'b11, 2'b00, 2'b00};
    t_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0064, 32'h0000_1234};
    t_b  = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000};
    t_e  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234};
    t_l  = '{38, 38, 3, 3};
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_sm[i], t_a[i], t_b[i], 5'(i + 12), t_e[i], 1'b1, ok);
      n_checks++; if (!ok) $display("FAIL div_accept[%0d] got=0 exp=1", i); else n_pass++;
      wait_rsp(lat, ez);
      n_checks++; if (lat != t_l[i]) $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, t_l[i]); else n_pass++;
      n_checks++; if (ez !== (t_b[i] == 32'd0)) $display("FAIL div_eq_zero[%0d] got=%b exp=%b", i, ez, (t_b[i] == 32'd0)); else n_pass++;
      take_rsp(e, r, d);
      n_checks++; if (r !== e.res) $display("FAIL div_result[%0d] got=%h exp=%h", i, r, e.res); else n_pass++;
      n_checks++; if (d !== e.rd) $display("FAIL div_rd[%0d] got=%0d exp=%0d", i, d, e.rd); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ez, seen_ready;
    int lat;
    exp_t e;
    logic [31:0] r;
    logic [4:0] d;
    issue(2'd0, 2'b00, 32'h10, 32'h20, 5'd9, 32'h0000_0200, 1'b1, ok);
    n_checks++; if (!ok) $display("FAIL b2b_accept got=0 exp=1"); else n_pass++;
    wait_rsp(lat, ez);
    n_checks++; if (lat != 34) $display("FAIL b2b_latency0 got=%0d exp=34", lat); else n_pass++;
    // Writeback stalls for five cycles: the response must hold still.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      $display("hold cycle %0d valid=%b result=%h rd=%0d", c, rsp_valid_o, rsp_result_o, rsp_rd_o);
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h200 || rsp_rd_o !== 5'd9 || md_mult_en_o !== 1'b0 || req_ready_o !== 1'b0)
        $display("FAIL hold[%0d] got=%b/%h/%0d/en%b/rdy%b exp=1/00000200/9/en0/rdy0", c, rsp_valid_o, rsp_result_o, rsp_rd_o, md_mult_en_o, req_ready_o);
      else n_pass++;
    end
    // Retire the held result and issue the next op on the same edge.
    sb.push_back('{res: 32'h0000_0001, rd: 5'd10});
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_operator_i = 2'd0; req_signed_mode_i = 2'b11;
    req_op_a_i = 32'hFFFF_FFFF; req_op_b_i = 32'hFFFF_FFFF; req_rd_i = 5'd10;
    @(negedge clk);
    seen_ready = req_ready_o;
    e = sb.pop_front();
    r = rsp_result_o;
    d = rsp_rd_o;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    $display("b2b retire result=%h rd=%0d, next issued", r, d);
    n_checks++; if (seen_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", seen_ready); else n_pass++;
    n_checks++; if (r !== e.res || d !== e.rd) $display("FAIL b2b_first got=%h/%0d exp=%h/%0d", r, d, e.res, e.rd); else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b0 || md_mult_en_o !== 1'b1) $display("FAIL b2b_run got=valid%b/en%b exp=valid0/en1", rsp_valid_o, md_mult_en_o); else n_pass++;
    wait_rsp(lat, ez);
    n_checks++; if (lat != 34) $display("FAIL b2b_latency1 got=%0d exp=34", lat); else n_pass++;
    take_rsp(e, r, d);
    n_checks++; if (r !== e.res || d !== e.rd) $display("FAIL b2b_second got=%h/%0d exp=%h/%0d", r, d, e.res, e.rd); else n_pass++;
  endtask

  task automatic test_flush_drain();
    bit ok, ez, en_ok, no_rsp, no_rdy;
    int cyc, lat;
    exp_t e;
    logic [31:0] r;
    logic [4:0] d;
    issue(2'd2, 2'b11, 32'd100, 32'd7, 5'd20, 32'd0, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL flush_accept got=0 exp=1"); else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    cyc = 11; en_ok = 1'b1; no_rsp = 1'b1; no_rdy = 1'b1;
    while (busy_o && cyc < 100) begin
      en_ok  = en_ok & md_div_en_o;
      no_rsp = no_rsp & ~rsp_valid_o;
      no_rdy = no_rdy & ~req_ready_o;
      @(posedge clk); #1;
      cyc++;
    end
    $display("drain ended at cycle %0d", cyc);
    n_checks++; if (en_ok !== 1'b1) $display("FAIL drain_enable got=0 exp=1"); else n_pass++;
    n_checks++; if (no_rsp !== 1'b1) $display("FAIL drain_no_rsp got=0 exp=1"); else n_pass++;
    n_checks++; if (no_rdy !== 1'b1) $display("FAIL drain_not_ready got=0 exp=1"); else n_pass++;
    n_checks++; if (cyc != 38) $display("FAIL drain_end_cycle got=%0d exp=38", cyc); else n_pass++;
    n_checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) $display("FAIL drain_idle got=rdy%b/valid%b exp=rdy1/valid0", req_ready_o, rsp_valid_o); else n_pass++;
    issue(2'd0, 2'b00, 32'd3, 32'd5, 5'd11, 32'd15, 1'b1, ok);
    wait_rsp(lat, ez);
    n_checks++; if (lat != 34) $display("FAIL post_flush_latency got=%0d exp=34", lat); else n_pass++;
    take_rsp(e, r, d);
    n_checks++; if (r !== e.res || d !== e.rd) $display("FAIL post_flush_result got=%h/%0d exp=%h/%0d", r, d, e.res, e.rd); else n_pass++;
  endtask

  task automatic test_flush_edges();
    bit ok, ez;
    int n, lat;
    // Flush arriving together with the unit's result pulse.
    issue(2'd0, 2'b00, 32'd2, 32'd2, 5'd21, 32'd0, 1'b0, ok);
    n = 0;
    while (!md_valid_i && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("flush with valid: busy=%b rsp_valid=%b", busy_o, rsp_valid_o);
    n_checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) $display("FAIL flush_with_valid got=busy%b/valid%b exp=busy0/valid0", busy_o, rsp_valid_o); else n_pass++;
    // Flush while the response waits for writeback.
    issue(2'd0, 2'b00, 32'd2, 32'd3, 5'd22, 32'd0, 1'b0, ok);
    wait_rsp(lat, ez);
    n_checks++; if (rsp_valid_o !== 1'b1) $display("FAIL resp_before_flush got=%b exp=1", rsp_valid_o); else n_pass++;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    $display("flush in resp: busy=%b rsp_valid=%b", busy_o, rsp_valid_o);
    n_checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) $display("FAIL flush_in_resp got=busy%b/valid%b exp=busy0/valid0", busy_o, rsp_valid_o); else n_pass++;
  endtask

  task automatic test_watchdog_and_reset();
    bit ok, ez;
    int lat;
    exp_t e;
    logic [31:0] r;
    logic [4:0] d;
    unit_stall = 1'b1;
    issue(2'd0, 2'b00, 32'd1, 32'd1, 5'd23, 32'd0, 1'b0, ok);
    repeat (39) @(posedge clk);
    #1;
    n_checks++; if (err_o !== 1'b0) $display("FAIL wd_early got=%b exp=0", err_o); else n_pass++;
    @(posedge clk); #1;
    $display("watchdog at 40 cycles err=%b", err_o);
    n_checks++; if (err_o !== 1'b1) $display("FAIL wd_set got=%b exp=1", err_o); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (err_o !== 1'b1) $display("FAIL wd_sticky got=%b exp=1", err_o); else n_pass++;
    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    $display("async reset: busy=%b err=%b en=%b%b", busy_o, err_o, md_mult_en_o, md_div_en_o);
    n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) $display("FAIL async_reset got=busy%b/err%b exp=busy0/err0", busy_o, err_o); else n_pass++;
    n_checks++; if ({md_mult_en_o, md_div_en_o} !== 2'b00 || md_op_a_o !== 32'd0) $display("FAIL async_reset_unit got=en%b%b/a%h exp=en00/a0", md_mult_en_o, md_div_en_o, md_op_a_o); else n_pass++;
    unit_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'd0, 2'b00, 32'd6, 32'd7, 5'd24, 32'd42, 1'b1, ok);
    wait_rsp(lat, ez);
    n_checks++; if (lat != 34) $display("FAIL recover_latency got=%0d exp=34", lat); else n_pass++;
    take_rsp(e, r, d);
    n_checks++; if (r !== e.res || d !== e.rd) $display("FAIL recover_result got=%h/%0d exp=%h/%0d", r, d, e.res, e.rd); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL scoreboard_empty got=%0d exp=0", sb.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_adder();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush_drain();
    test_flush_edges();
    test_watchdog_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a stuck DUT defeats every bounded wait.
  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
